muldiv_seq: RTL

Iterative multiply/divide sequencer for the MIPS HI/LO unit. It runs a single shared WIDTH-bit adder/subtractor for MULT, MULTU, DIV and DIVU, one bit per cycle, and owns the HI and LO registers. It sits beside the execute stage. The pipeline hazard logic stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shared adder/subtractor, one result bit per cycle, WIDTH+2 cycles per operation.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;        // original dividend, kept for divide-by-zero
    logic [WIDTH-1:0]   opb_q;      // multiplicand-side / divisor operand (magnitude after PREP)
    logic [2*WIDTH-1:0] acc_q;      // {partial product | remainder, multiplier | dividend/quotient}
    logic [CntW-1:0]    cnt_q;
    logic               neg_res_q;  // operand signs differ
    logic               neg_rem_q;  // dividend was negative

    logic               is_div;
    logic [WIDTH-1:0]   upper, lower;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     add_x, add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   sum;
    logic               no_borrow;
    logic [2*WIDTH-1:0] acc_step;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign is_div = op_q[1];
    assign upper  = acc_q[2*WIDTH-1:WIDTH];
    assign lower  = acc_q[WIDTH-1:0];
    assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort flushes any in-flight operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && !abort) state_d = StPrep;
            StPrep: state_d = abort ? StIdle : StRun;
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shared adder: add for multiply, trial subtract (carry-out = no borrow) for divide
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (is_div) begin
            add_x   = rem_sh;
            add_y   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_x = {1'b0, upper};
            add_y = lower[0] ? {1'b0, opb_q} : '0;
        end
        sum       = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_cin};
        no_borrow = sum[WIDTH+1];
        if (is_div) begin
            acc_step = {(no_borrow ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        lower[WIDTH-2:0], no_borrow};
        end else begin
            acc_step = {sum[WIDTH:0], lower[WIDTH-1:1]};
        end
    end

    // Operand magnitudes for signed ops
    always_comb begin
        a_neg = op_q[0] & a_q[WIDTH-1];
        b_neg = op_q[0] & opb_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -opb_q : opb_q;
    end

    // Sign fixup and final HI/LO values
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (opb_q == '0) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = neg_res_q ? -lower : lower;
                fix_hi = neg_rem_q ? -upper : upper;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            a_q       <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        op_q  <= op;
                        a_q   <= a;
                        opb_q <= b;
                    end
                end
                StPrep: begin
                    acc_q     <= {{WIDTH{1'b0}}, a_mag};
                    opb_q     <= b_mag;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= '0;
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HI/LO: MTHI/MTLO only when idle; result written on completion unless aborted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state_q == StIdle) begin
            if (hiwrite) hi <= wdata;
            if (lowrite) lo <= wdata;
        end else if (state_q == StFix && !abort) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != StIdle);
            done <= (state_q == StFix) && !abort;
        end
    end

endmodule
